// File: rtl/spi_frame_pkg.sv
// Shared constants and FSM encoding for the SPI frame unpacker.
// Frame geometry, command bit positions and the state enumeration live here.
package spi_frame_pkg;

    localparam int FRAME_W   = 1024;
    localparam int WORD_W    = 16;
    localparam int MAX_WORDS = 62;

    localparam int CMD_EN = 0;
    localparam int CMD_RD = 1;
    localparam int CMD_WR = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_VERIFY = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_frame_word_mux.sv
// Combinational payload word selector: picks word 'sel' out of the packed payload.
// Out-of-range selects return zero.
module spi_frame_word_mux
    import spi_frame_pkg::*;
#(
    parameter int NWORDS = MAX_WORDS,
    parameter int W      = WORD_W
)
(
    input  logic [NWORDS*W-1:0] payload,
    input  logic [5:0]          sel,
    output logic [W-1:0]        word
);

    always_comb begin
        word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (sel == 6'(k)) begin
                word = payload[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/spi_frame_unpacker.sv
// Captures a 1024-bit SPI frame, checks length and XOR checksum, then streams
// the payload words out over a valid/ready handshake.
module spi_frame_unpacker
    import spi_frame_pkg::state_t, spi_frame_pkg::S_IDLE, spi_frame_pkg::S_CHECK,
           spi_frame_pkg::S_VERIFY, spi_frame_pkg::S_EMIT, spi_frame_pkg::FRAME_W,
           spi_frame_pkg::CMD_EN, spi_frame_pkg::CMD_WR;
#(
    parameter int MAX_WORDS = 62,
    parameter int WORD_W    = 16
)
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [FRAME_W-1:0] FRAME_IN,
    input  logic               FRAME_STB,
    output logic [WORD_W-1:0]  WORD_OUT,
    output logic [5:0]         WORD_ADDR,
    output logic               WORD_VALID,
    input  logic               WORD_READY,
    output logic               FRAME_BUSY,
    output logic               FRAME_DONE,
    output logic               FRAME_OK,
    output logic               LEN_ERR,
    output logic               CRC_ERR,
    output logic [7:0]         OVERRUN_CNT,
    output state_t             DBG_STATE
);

    // Handshake: a word moves on every rising edge where WORD_VALID and WORD_READY
    // are both high; WORD_OUT/WORD_ADDR stay frozen while WORD_VALID waits for ready.

    state_t              state;
    logic [FRAME_W-1:8]  frame_q;
    logic [15:0]         acc;
    logic [5:0]          chk_cnt;
    logic [5:0]          sel;
    logic [WORD_W-1:0]   mux_word;
    logic [7:0]          n_in;
    logic [7:0]          n_q;
    logic                len_bad_in;
    logic                len_bad_q;
    logic                cmd_ok;
    logic                stb_accept;
    logic                last_check;
    logic                last_beat;

    assign n_in       = FRAME_IN[15:8];
    assign n_q        = frame_q[15:8];
    assign len_bad_in = (n_in == 8'd0) || (n_in > 8'(MAX_WORDS));
    assign len_bad_q  = (n_q == 8'd0) || (n_q > 8'(MAX_WORDS));
    assign cmd_ok     = FRAME_IN[CMD_EN] && FRAME_IN[CMD_WR];
    // The FRAME_DONE cycle still belongs to the finishing frame, so strobes there drop.
    assign stb_accept = FRAME_STB && (state == S_IDLE) && !FRAME_DONE;
    assign last_check = ({2'b00, chk_cnt} == n_q - 8'd1);
    assign last_beat  = ({2'b00, WORD_ADDR} == n_q - 8'd1);
    assign FRAME_BUSY = (state != S_IDLE);
    assign DBG_STATE  = state;

    // One selector serves both the checksum walk and the look-ahead for the next word.
    always_comb begin
        sel = 6'd0;
        case (state)
            S_CHECK: sel = chk_cnt;
            S_EMIT:  sel = WORD_ADDR + 6'd1;
            default: sel = 6'd0;
        endcase
    end

    spi_frame_word_mux #(
        .NWORDS (MAX_WORDS),
        .W      (WORD_W)
    ) u_word_mux (
        .payload (frame_q[16 + MAX_WORDS*WORD_W - 1 : 16]),
        .sel     (sel),
        .word    (mux_word)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            frame_q     <= '0;
            acc         <= '0;
            chk_cnt     <= '0;
            WORD_OUT    <= '0;
            WORD_ADDR   <= '0;
            WORD_VALID  <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_OK    <= 1'b0;
            LEN_ERR     <= 1'b0;
            CRC_ERR     <= 1'b0;
            OVERRUN_CNT <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (FRAME_STB && !stb_accept && (OVERRUN_CNT != 8'hFF)) begin
                OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (stb_accept) begin
                        frame_q <= FRAME_IN[FRAME_W-1:8];
                        if (cmd_ok) begin
                            FRAME_OK <= 1'b0;
                            LEN_ERR  <= 1'b0;
                            CRC_ERR  <= 1'b0;
                            acc      <= FRAME_IN[15:0];
                            chk_cnt  <= 6'd0;
                            state    <= len_bad_in ? S_VERIFY : S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    acc     <= acc ^ mux_word;
                    chk_cnt <= chk_cnt + 6'd1;
                    if (last_check) begin
                        state <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (len_bad_q) begin
                        LEN_ERR    <= 1'b1;
                        FRAME_DONE <= 1'b1;
                        state      <= S_IDLE;
                    end else if (acc != frame_q[FRAME_W-1 -: 16]) begin
                        CRC_ERR    <= 1'b1;
                        FRAME_DONE <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        FRAME_OK   <= 1'b1;
                        WORD_OUT   <= mux_word;
                        WORD_ADDR  <= 6'd0;
                        WORD_VALID <= 1'b1;
                        state      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (WORD_READY) begin
                        if (last_beat) begin
                            WORD_VALID <= 1'b0;
                            FRAME_DONE <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            WORD_ADDR <= WORD_ADDR + 6'd1;
                            WORD_OUT  <= mux_word;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_unpacker.sv
// Scoreboard bench for spi_frame_unpacker: stimulus pushes expected words and
// frame status from a reference model; a negedge monitor pops and compares.
module tb_spi_frame_unpacker;
    import spi_frame_pkg::state_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [1023:0] FRAME_IN = '0;
    logic          FRAME_STB = 1'b0;
    logic          WORD_READY = 1'b0;
    logic [15:0]   WORD_OUT;
    logic [5:0]    WORD_ADDR;
    logic          WORD_VALID;
    logic          FRAME_BUSY;
    logic          FRAME_DONE;
    logic          FRAME_OK;
    logic          LEN_ERR;
    logic          CRC_ERR;
    logic [7:0]    OVERRUN_CNT;
    state_t        DBG_STATE;

    spi_frame_unpacker dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FRAME_IN    (FRAME_IN),
        .FRAME_STB   (FRAME_STB),
        .WORD_OUT    (WORD_OUT),
        .WORD_ADDR   (WORD_ADDR),
        .WORD_VALID  (WORD_VALID),
        .WORD_READY  (WORD_READY),
        .FRAME_BUSY  (FRAME_BUSY),
        .FRAME_DONE  (FRAME_DONE),
        .FRAME_OK    (FRAME_OK),
        .LEN_ERR     (LEN_ERR),
        .CRC_ERR     (CRC_ERR),
        .OVERRUN_CNT (OVERRUN_CNT),
        .DBG_STATE   (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [21:0] exp_q[$];      // {addr, word}
    logic [2:0]  exp_st_q[$];   // {ok, len_err, crc_err}
    int          stb_cyc = 0;
    int          first_valid_rel = -1;
    int          done_rel = -1;
    int          done_cnt = 0;
    int          rdy_mode = 0;  // 0 always, 1 one-in-three, 2 random, 3 never
    logic [15:0] pw[62];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycle();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1023:0] make_frame(input logic [7:0] cmd, input logic [7:0] n,
                                                 input logic [15:0] corrupt);
        logic [1023:0] f = '0;
        logic [15:0]   cs;
        f[7:0]  = cmd;
        f[15:8] = n;
        cs = {n, cmd};
        for (int k = 0; k < 62; k++) begin
            f[16*k+16 +: 16] = pw[k];
            if (k < int'(n)) cs ^= pw[k];
        end
        f[1023:1008] = cs ^ corrupt;
        return f;
    endfunction

    function automatic void expect_frame(input logic [1023:0] f);
        int n = int'(f[15:8]);
        logic [15:0] x;
        if (!(f[0] && f[2])) return;
        if (n == 0 || n > 62) begin
            exp_st_q.push_back(3'b010);
            return;
        end
        x = f[15:0];
        for (int k = 0; k < n; k++) x ^= f[16*k+16 +: 16];
        if (x != f[1023:1008]) begin
            exp_st_q.push_back(3'b001);
            return;
        end
        for (int k = 0; k < n; k++) exp_q.push_back({6'(k), f[16*k+16 +: 16]});
        exp_st_q.push_back(3'b100);
    endfunction

    // ---------------- drivers ----------------
    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       WORD_READY = 1'b1;
            1:       WORD_READY = (cyc % 3 == 0);
            2:       WORD_READY = 1'($urandom_range(0, 1));
            default: WORD_READY = 1'b0;
        endcase
    end

    task automatic fill_random();
        for (int k = 0; k < 62; k++) pw[k] = 16'($urandom);
    endtask

    task automatic send_frame(input logic [1023:0] f);
        stb_cyc = cyc;
        first_valid_rel = -1;
        done_rel = -1;
        expect_frame(f);
        FRAME_IN = f;
        FRAME_STB = 1'b1;
        wait_cycle();
        FRAME_STB = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, input string name);
        int i = 0;
        while (done_cnt == prev && i < budget) begin
            wait_cycle();
            i++;
        end
        check({name, "_done_timeout"}, 32'(done_cnt != prev), 32'd1);
        wait_cycle();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, 32'({WORD_VALID, FRAME_BUSY, FRAME_DONE, FRAME_OK, LEN_ERR, CRC_ERR}), 32'd0);
        check({tag, "_word_out"}, 32'(WORD_OUT), 32'd0);
        check({tag, "_word_addr"}, 32'(WORD_ADDR), 32'd0);
        check({tag, "_overrun"}, 32'(OVERRUN_CNT), 32'd0);
    endtask

    // ---------------- monitor ----------------
    bit          held = 1'b0;
    logic [21:0] prev_beat = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("valid_held_while_stalled", 32'(WORD_VALID), 32'd1);
                if (WORD_VALID) check("beat_stable_while_stalled", 32'({WORD_ADDR, WORD_OUT}), 32'(prev_beat));
            end
            if (WORD_VALID) begin
                if (first_valid_rel < 0) first_valid_rel = cyc - stb_cyc;
                if (WORD_READY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'({WORD_ADDR, WORD_OUT}), 32'hFFFF_FFFF);
                    end else begin
                        check("word_beat", 32'({WORD_ADDR, WORD_OUT}), 32'(exp_q.pop_front()));
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev_beat = {WORD_ADDR, WORD_OUT};
                end
            end else begin
                held = 1'b0;
            end
            if (FRAME_DONE) begin
                done_cnt++;
                done_rel = cyc - stb_cyc;
                if (exp_st_q.size() == 0) begin
                    check("unexpected_done", 32'({FRAME_OK, LEN_ERR, CRC_ERR}), 32'hFFFF_FFFF);
                end else begin
                    check("frame_status", 32'({FRAME_OK, LEN_ERR, CRC_ERR}), 32'(exp_st_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int prev;
        logic [7:0] n;
        wait_cycle();
        wait_cycle();
        check_idle("reset");
        RESET = 1'b0;
        wait_cycle();

        // Nominal three-word frame.
        rdy_mode = 0;
        fill_random();
        pw[0] = 16'h1111; pw[1] = 16'h2222; pw[2] = 16'h3333;
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd3, 16'h0000));
        wait_done(prev, 50, "ok3");
        check("ok3_first_valid_cycle", 32'(first_valid_rel), 32'd5);
        check("ok3_done_cycle", 32'(done_rel), 32'd8);
        check("ok3_frame_ok", 32'(FRAME_OK), 32'd1);
        check("ok3_words_drained", 32'(exp_q.size()), 32'd0);

        // Checksum off by one bit.
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd3, 16'h0001));
        wait_done(prev, 50, "crc");
        check("crc_no_valid", 32'(first_valid_rel), 32'hFFFF_FFFF);
        check("crc_done_cycle", 32'(done_rel), 32'd5);
        check("crc_status", 32'({FRAME_OK, LEN_ERR, CRC_ERR}), 32'b001);

        // Length errors at both ends.
        foreach (pw[k]) pw[k] = 16'(k * 7 + 1);
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? 8'd0 : 8'd63;
            prev = done_cnt;
            send_frame(make_frame(8'h05, n, 16'h0000));
            wait_done(prev, 20, "len");
            check("len_done_cycle", 32'(done_rel), 32'd2);
            check("len_no_valid", 32'(first_valid_rel), 32'hFFFF_FFFF);
            check("len_status", 32'({FRAME_OK, LEN_ERR, CRC_ERR}), 32'b010);
        end

        // Commands missing enable or write are ignored and leave status alone.
        for (int i = 0; i < 2; i++) begin
            prev = done_cnt;
            send_frame(make_frame((i == 0) ? 8'h03 : 8'h04, 8'd3, 16'h0000));
            repeat (8) wait_cycle();
            check("badcmd_no_done", 32'(done_cnt), 32'(prev));
            check("badcmd_status_held", 32'({FRAME_OK, LEN_ERR, CRC_ERR}), 32'b010);
            check("badcmd_idle", 32'(FRAME_BUSY), 32'd0);
        end

        // Random frames with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            fill_random();
            n = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(63, 255)) : 8'($urandom_range(1, 62));
            if ($urandom_range(0, 7) == 0) n = 8'd0;
            prev = done_cnt;
            send_frame(make_frame(8'($urandom) | 8'h05, n,
                                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000));
            wait_done(prev, 600, "rand");
        end

        // Full 62-word frame, ready one cycle in three.
        rdy_mode = 1;
        fill_random();
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd62, 16'h0000));
        wait_done(prev, 400, "full62");
        check("full62_words_drained", 32'(exp_q.size()), 32'd0);

        // Strobe in the FRAME_DONE cycle is dropped; the next cycle is accepted.
        rdy_mode = 0;
        fill_random();
        send_frame(make_frame(8'h05, 8'd2, 16'h0000));
        for (int i = 0; i < 40 && !FRAME_DONE; i++) wait_cycle();
        check("donecyc_seen", 32'(FRAME_DONE), 32'd1);
        FRAME_IN = make_frame(8'h05, 8'd4, 16'h0000);
        FRAME_STB = 1'b1;
        wait_cycle();
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd2, 16'h0000));
        wait_done(prev, 50, "after_done");
        check("after_done_cycle", 32'(done_rel), 32'd6);
        check("donecyc_overrun", 32'(OVERRUN_CNT), 32'd1);

        // 300 strobes against a stalled EMIT.
        rdy_mode = 3;
        fill_random();
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd62, 16'h0000));
        for (int i = 0; i < 100 && !WORD_VALID; i++) wait_cycle();
        check("overrun_emit_reached", 32'(WORD_VALID), 32'd1);
        for (int i = 0; i < 300; i++) begin
            FRAME_IN = {32{$urandom}};
            FRAME_IN[7:0] = 8'h05;
            FRAME_STB = 1'b1;
            wait_cycle();
            FRAME_STB = 1'b0;
            wait_cycle();
        end
        check("overrun_saturated", 32'(OVERRUN_CNT), 32'd255);
        check("overrun_still_busy", 32'(FRAME_BUSY), 32'd1);
        rdy_mode = 0;
        wait_done(prev, 200, "overrun");
        check("overrun_words_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of EMIT.
        rdy_mode = 1;
        fill_random();
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd20, 16'h0000));
        for (int i = 0; i < 200 && !(WORD_VALID && WORD_ADDR == 6'd10); i++) wait_cycle();
        check("midreset_addr10_reached", 32'(WORD_ADDR), 32'd10);
        #2;
        RESET = 1'b1;
        #1;
        check_idle("midreset");
        exp_q.delete();
        exp_st_q.delete();
        wait_cycle();
        wait_cycle();
        RESET = 1'b0;
        repeat (4) wait_cycle();
        check("midreset_no_done", 32'(done_cnt), 32'(prev));

        rdy_mode = 0;
        fill_random();
        prev = done_cnt;
        send_frame(make_frame(8'h05, 8'd3, 16'h0000));
        wait_done(prev, 50, "post_reset");
        check("post_reset_done_cycle", 32'(done_rel), 32'd8);
        check("post_reset_frame_ok", 32'(FRAME_OK), 32'd1);

        check("final_word_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_status_queue_empty", 32'(exp_st_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_unpacker.md
SPI_FRAME_UNPACKER -- requirements
Module: spi_frame_unpacker

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 62, meaning the number of payload word slots in a 1024-bit frame.
REQ-002 SHALL have parameter WORD_W, default 16, meaning the payload word width in bits.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port FRAME_IN, input, 1024 bits: the received SPI frame from the SPI slave stage.
REQ-006 SHALL have port FRAME_STB, input, 1 bit: a one-cycle pulse indicating that FRAME_IN has just been updated.
REQ-007 SHALL have port WORD_OUT, output, 16 bits: the payload word currently offered.
REQ-008 SHALL have port WORD_ADDR, output, 6 bits: the index (0..61) of WORD_OUT.
REQ-009 SHALL have port WORD_VALID, output, 1 bit; and port WORD_READY, input, 1 bit: the downstream handshake.
REQ-010 SHALL have port FRAME_BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port FRAME_DONE, output, 1 bit: a one-cycle end-of-frame pulse.
REQ-012 SHALL have ports FRAME_OK, LEN_ERR and CRC_ERR, output, 1 bit each: the status of the last accepted frame.
REQ-013 SHALL have port OVERRUN_CNT, output, 8 bits: a saturating count of dropped frames.

Function
REQ-014 SHALL use the following frame layout:
- [7:0] command: bit0 enable, bit1 read, bit2 write.
- [15:8] word count N.
- Word k (k = 0..61) at [16k+31:16k+16].
- [1023:1008] checksum.
REQ-015 SHALL accept FRAME_STB only in IDLE, capturing FRAME_IN into an internal register at that edge.
REQ-016 SHALL go from IDLE back to IDLE (no status change, no FRAME_DONE) when the captured command bit0 or bit2 is 0.
REQ-017 SHALL implement four states, IDLE, CHECK, VERIFY and EMIT, with these transitions:
- IDLE -> CHECK on an accepted frame with a valid command.
- CHECK -> VERIFY after N cycles.
- VERIFY -> EMIT if OK, else -> IDLE.
- EMIT -> IDLE after the last handshake.
REQ-018 SHALL treat N=0 or N>62 as a length error: CHECK is skipped, VERIFY is entered the next cycle, and LEN_ERR=1, CRC_ERR=0, FRAME_OK=0.
REQ-019 SHALL initialise a 16-bit accumulator with the header word [15:0] at capture, then XOR in one payload word per CHECK cycle (words 0..N-1).
REQ-020 SHALL compare the accumulator with [1023:1008] in VERIFY:
- Mismatch sets CRC_ERR=1, FRAME_OK=0.
- Match sets FRAME_OK=1.
REQ-021 SHALL produce the first WORD_VALID in cycle N+2, where the FRAME_STB cycle is cycle 0.
REQ-022 SHALL, in EMIT, hold WORD_VALID high with WORD_OUT and WORD_ADDR stable until WORD_READY=1; a transfer occurs on any edge where both are high.
REQ-023 SHALL increment WORD_ADDR from 0 by 1 per transfer; the transfer with WORD_ADDR=N-1 deasserts WORD_VALID at the next edge.
REQ-024 SHALL pulse FRAME_DONE for exactly one cycle:
- the cycle after the final transfer, or
- the cycle after VERIFY on an error.
REQ-025 SHALL hold FRAME_OK, LEN_ERR and CRC_ERR from FRAME_DONE until the next accepted valid-command frame, which clears all three at capture.
REQ-026 SHALL drop any FRAME_STB arriving in a non-IDLE state (including the FRAME_DONE cycle), increment OVERRUN_CNT saturating at 255, and leave the frame in progress unaffected.
REQ-027 SHALL accept a FRAME_STB in the cycle after FRAME_DONE.
REQ-028 SHALL hold WORD_VALID=0 in all states except EMIT.

Reset
REQ-029 SHALL force, on RESET=1 (asynchronously, at any time including mid-frame):
- state IDLE;
- WORD_VALID=0, WORD_OUT=0, WORD_ADDR=0;
- FRAME_BUSY=0, FRAME_DONE=0, FRAME_OK=0, LEN_ERR=0, CRC_ERR=0;
- OVERRUN_CNT=0;
- frame register and accumulator cleared.
REQ-030 SHALL discard a partially emitted frame on reset, with no FRAME_DONE generated.

Structure
REQ-031 SHALL place the following in shared package spi_frame_pkg:
- FRAME_W=1024, WORD_W=16, MAX_WORDS=62;
- command bit positions CMD_EN=0, CMD_RD=1, CMD_WR=2;
- the state enumeration.
REQ-032 SHALL implement the 62:1 word selector (indexed by CHECK counter or WORD_ADDR) as one combinational sub-module, spi_frame_word_mux.

Verification
REQ-033 SHALL cover: command 0x05, N=3, words 0x1111/0x2222/0x3333, correct checksum, WORD_READY=1 -> WORD_VALID in cycles 5..7 at addresses 0,1,2, FRAME_DONE in cycle 8, FRAME_OK=1.
REQ-034 SHALL cover: the same frame with the checksum XORed by 0x0001 -> no WORD_VALID, FRAME_DONE in cycle 5, CRC_ERR=1.
REQ-035 SHALL cover: N=0 and N=63 -> FRAME_DONE in cycle 2, LEN_ERR=1, no WORD_VALID.
REQ-036 SHALL cover: N=62 with WORD_READY toggling 1-of-3 -> 62 transfers in address order, each word held stable while stalled.
REQ-037 SHALL cover: FRAME_STB repeated 300 times during a stalled EMIT -> OVERRUN_CNT=255, current frame completes intact.
REQ-038 SHALL cover: RESET pulsed during EMIT at WORD_ADDR=10 -> all outputs reach their reset values asynchronously, no FRAME_DONE, next frame processed normally.
